// File: rtl/krz_map_pkg.sv
// Shared krz peripheral map constants used by the UART receive path.
package krz_map;

  localparam int unsigned UART_RX_DEPTH  = 64;
  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for the UART receiver; pointers carry an extra MSB
// so full/empty are told apart by comparing the wrap bit.
module uart_rx_fifo
  import krz_map::*;
#(
  parameter int unsigned DEPTH = UART_RX_DEPTH
) (
  input  logic                        clk,
  input  logic                        rstz,
  input  logic                        clear,
  input  logic                        push,
  input  logic [UART_DATA_BITS-1:0]   din,
  input  logic                        pop,
  output logic [UART_DATA_BITS-1:0]   dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW:0]               wr_ptr;
  logic [AW:0]               rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // A flush swallows any push or pop landing in the same cycle.
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver with RX FIFO on the krz peripheral bus.
// Optional stop-bit checking and sticky frame_err: KRZ_UART_RX_FRAME_CHECK_EN.
module wb_uart_rx
  import krz_map::*;
#(
  parameter int unsigned DEPTH = UART_RX_DEPTH
) (
  input  logic                      clk,
  input  logic                      rstz,
  input  logic                      rx,
  input  logic [15:0]               prescaler,
  input  logic                      clear,
  output logic [15:0]               size,
  output logic                      frame_err,
  output logic [UART_DATA_BITS-1:0] dat_o,
  input  logic                      we_i,
  input  logic                      stb_i,
  output logic                      ack_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                    state;
  logic                      rx_meta;
  logic                      rx_sync;
  logic                      rx_prev;
  logic                      fall;
  logic [15:0]               cnt;
  logic [15:0]               presc_q;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      cnt_zero;
  logic                      push;
  logic                      rd_ok;
  logic                      wr_ok;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [UART_DATA_BITS-1:0] fifo_head;
  logic [$clog2(DEPTH):0]    fifo_count;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall     = rx_prev & ~rx_sync;
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state   <= IDLE;
      cnt     <= '0;
      presc_q <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            cnt     <= prescaler >> 1;
            presc_q <= prescaler;
            state   <= START;
          end
        end
        START: begin
          if (cnt_zero) begin
            if (!rx_sync) begin
              cnt     <= presc_q;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (cnt_zero) begin
            shreg   <= {rx_sync, shreg[UART_DATA_BITS-1:1]};
            cnt     <= presc_q;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          if (cnt_zero) state <= IDLE;
          else          cnt   <= cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KRZ_UART_RX_FRAME_CHECK_EN
  logic stop_bad;

  assign stop_bad = (state == STOP) & cnt_zero & ~rx_sync;
  assign push     = (state == STOP) & cnt_zero & rx_sync;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz)         frame_err <= 1'b0;
    else if (clear)    frame_err <= 1'b0;
    else if (stop_bad) frame_err <= 1'b1;
  end
`else
  assign push      = (state == STOP) & cnt_zero;
  assign frame_err = 1'b0;
`endif

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstz  (rstz),
    .clear (clear),
    .push  (push),
    .din   (shreg),
    .pop   (rd_ok),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign size = 16'(fifo_count);

  // Gating on ack_o spaces acks so a held strobe is not double-served.
  assign rd_ok = stb_i & ~we_i & ~ack_o & ~fifo_empty & ~clear;
  assign wr_ok = stb_i & we_i & ~ack_o;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= rd_ok | wr_ok;
      if (rd_ok) dat_o <= fifo_head;
    end
  end

endmodule
